uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
UART transmitter with a small byte FIFO. It accepts bytes over a valid/ready handshake and serialises them onto the line as 8N1 frames, LSB first, at N clocks per bit. It is the upstream stage of uart_rx, which samples the same line at the same N.

Parameters:
N, 8, clocks per bit; must match the uart_rx instance on the far end; N >= 2
FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_vld  input  1  byte offered on tx_data
tx_data  input  8  byte to transmit
tx_rdy  output  1  FIFO can accept a byte; high when count < FIFO_DEPTH
uart_data  output  1  serial line; idles high; registered output
tx_busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: uart_data=1, tx_rdy=1, tx_busy=0, FIFO empty, FSM=IDLE, all counters 0.
- Push: a byte is written on a rising edge where tx_vld && tx_rdy. tx_vld with tx_rdy=0 is ignored; the source must hold the byte. tx_rdy depends only on the FIFO count, never on tx_vld.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- Counters: cnt counts 0..N-1 within a bit; idx counts 0..7 for data bits.
- IDLE: if the FIFO is non-empty, pop into shift register sh, set uart_data=0, cnt=0, go to START. Otherwise uart_data=1.
- START -> DATA: when cnt==N-1, uart_data=sh[0], idx=0.
- DATA: at cnt==N-1, shift sh right. If idx<7, idx+1 and drive the next bit. If idx==7, uart_data=1 and go to STOP.
- STOP, at cnt==N-1:
  - FIFO non-empty: pop, uart_data=0, go to START. Frames are back-to-back with no idle gap.
  - FIFO empty: go to IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE gives a uart_data falling edge after edge k+1.
- Bit timing: every bit lasts exactly N cycles. A frame is 10*N cycles.
- Simultaneous push and pop: the count is unchanged and both take effect. The FIFO is read-before-write safe when it holds 1 entry.
- Full: the count reaches FIFO_DEPTH and tx_rdy drops after that edge. tx_rdy rises the cycle after the next pop.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits.
- tx_busy: registered. It falls on the same edge the FSM returns to IDLE with the FIFO empty.
- Reset mid-frame: uart_data returns to 1 immediately (asynchronous) and FIFO contents are discarded. No partial frame resumes after release.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives an even-parity bit (XOR of the 8 data bits) for N cycles. A frame is 11*N cycles.
- Undefined: no parity logic and no PARITY state. Frame is 8N1 at 10*N cycles.

Test Plan:
- Reset: hold rst_n low 2 cycles -> uart_data=1, tx_rdy=1, tx_busy=0. Idle 100 cycles -> no line activity.
- Single byte 0x4B, N=8:
  - uart_data falls 1 cycle after accept.
  - Line sequence 0,1,1,0,1,0,0,1,0,1, each held 8 cycles.
  - tx_busy falls 80 cycles after the start edge.
- Burst of 6 bytes 0x00,0xFF,0x55,0xA5,0x3C,0x81 offered on consecutive cycles, DEPTH=4:
  - Bytes 1-5 accepted; tx_rdy low while the 6th is offered.
  - The 6th is accepted the cycle after the frame-1 stop-bit pop.
  - Six contiguous frames with no idle cycles; tx_busy stays high for 480 cycles.
- Loopback: connect uart_data to uart_rx (N=8), send 0x4B then 0xA5 -> rx_vld pulses twice with rx_data 0x4B, then 0xA5.
- Reset mid-frame: assert rst_n during bit D3 of 0x4B with 2 bytes queued -> uart_data=1 within the same cycle, tx_rdy=1, tx_busy=0. After release, no frame is emitted.
- With UART_TX_PARITY_EN: 0x4B -> parity bit 0; 0x01 -> parity bit 1. Each frame is 88 cycles, and the stop bit starts at cycle 80.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first, N clocks per bit) fed by a FIFO_DEPTH-entry byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (11*N-cycle frame).
module uart_tx_fifo #(
    parameter int unsigned N          = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_vld,
    input  logic [7:0] tx_data,
    output logic       tx_rdy,
    output logic       uart_data,
    output logic       tx_busy
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_ne;
    logic [7:0]    w_head;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_sh;
    logic [7:0]    w_sh_nxt;
    logic          r_line;
    logic          w_line_nxt;
    logic          r_busy;
    logic          w_last;
`ifdef UART_TX_PARITY_EN
    logic          r_par;
    logic          w_par_nxt;
`endif

    assign tx_rdy    = (r_count < DEPTH_C);
    assign w_push    = tx_vld && tx_rdy;
    assign w_fifo_ne = (r_count != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_last    = (r_cnt == CNT_LAST);
    assign uart_data = r_line;
    assign tx_busy   = r_busy;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_line  <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
            r_line  <= w_line_nxt;
            r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    // The line register is loaded with the value of the upcoming bit on the
    // edge that ends the current one, so uart_data is glitch-free and registered.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_last ? '0 : r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_line_nxt  = r_line;
        w_pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_line_nxt = 1'b1;
                if (w_fifo_ne) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_head;
                    w_line_nxt  = 1'b0;
                    w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = ^w_head;
`endif
                end
            end
            S_START: begin
                if (w_last) begin
                    w_idx_nxt   = '0;
                    w_line_nxt  = r_sh[0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_sh_nxt = {1'b0, r_sh[7:1]};
                    if (r_idx != 3'd7) begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_line_nxt = r_sh[1];
                    end else begin
`ifdef UART_TX_PARITY_EN
                        w_line_nxt  = r_par;
                        w_state_nxt = S_PARITY;
`else
                        w_line_nxt  = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_last) begin
                    w_line_nxt  = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_last) begin
                    if (w_fifo_ne) begin
                        w_pop       = 1'b1;
                        w_sh_nxt    = w_head;
                        w_line_nxt  = 1'b0;
                        w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
                        w_par_nxt   = ^w_head;
`endif
                    end else begin
                        w_line_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_line_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
